pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush controller for the 5-stage LC-3b pipeline. Drives load and flush
//  strobes of IF/ID, ID/EX, EX/MEM, MEM/WB registers and PC; ID/EX clear = reset | id_ex_flush.
//  Handles load-use interlock, imem/dmem wait states, MEM-stage branch redirect and the
//  two-access LDI/STI sequence (FSM). Keeps saturating stall/flush performance counters.
// PARAMETERS
//  CNT_WIDTH   16  width of stall_cycles / flush_events counters
//  EN_LOAD_USE 1   1 = detect load-use hazard; 0 = interlock disabled (forwarding-only debug)
// PORTS
//  clk            in   1  clock
//  reset          in   1  synchronous, active-high reset
//  id_src1        in   3  source reg 1 of instruction in ID
//  id_src2        in   3  source reg 2 of instruction in ID
//  id_src1_used   in   1  ID instruction reads src1
//  id_src2_used   in   1  ID instruction reads src2
//  ex_dest        in   3  dest reg of instruction in EX (ID/EX dest_out)
//  ex_is_load     in   1  EX instruction is LDR/LDB/LDI writing ex_dest
//  imem_req       in   1  fetch outstanding;  imem_resp in 1 fetch data valid
//  mem_dmem_req   in   1  MEM instruction accesses dmem;  dmem_resp in 1 dmem access done
//  mem_is_indirect in  1  MEM instruction is LDI or STI
//  mem_br_taken   in   1  branch/JMP/JSR/TRAP in MEM redirects PC
//  clr_counters   in   1  synchronous clear of both counters
//  pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load  out 1 each  register enables
//  if_id_flush, id_ex_flush, ex_mem_flush   out 1 each  load zeros (bubble) this edge
//  mem_ind_sel    out  1  0 = dmem addr from ALU (1st access), 1 = from fetched pointer
//  stall_cycles   out  CNT_WIDTH  cycles with pc_load=0 (saturates at all-ones)
//  flush_events   out  CNT_WIDTH  count of branch redirects (saturates)
// BEHAVIOUR
//  FSM states: RUN, IND2. Outputs Mealy (state + inputs); state/counters update on posedge.
//  reset=1: state<=RUN, counters<=0; all loads=0, all flushes=0, mem_ind_sel=0 (combinational).
//  Priority per cycle (highest first), all in RUN unless stated:
//   1 dmem_wait = mem_dmem_req & ~dmem_resp: all loads=0, flushes=0. State unchanged.
//   2 RUN & mem_is_indirect & dmem_resp: 1st access done -> all loads=0; next IND2.
//     IND2: mem_ind_sel=1; dmem_resp -> fall through to rules 3-6, next RUN; else hold.
//   3 mem_br_taken: all loads=1, if_id/id_ex/ex_mem_flush=1 (MEM/WB keeps branch for JSR R7).
//     Overrides load-use and imem wait; flush_events++.
//   4 load_use = EN_LOAD_USE & ex_is_load & ((id_src1_used & id_src1==ex_dest) |
//     (id_src2_used & id_src2==ex_dest)): pc_load=0, if_id_load=0, id_ex_load=1,
//     id_ex_flush=1, ex_mem_load=1, mem_wb_load=1. Exactly 1 bubble; next cycle relies on
//     MEM->EX forwarding.
//   5 imem_wait = imem_req & ~imem_resp: pc_load=0, if_id_load=0, bubble into ID/EX as in 4.
//   6 otherwise: all loads=1, all flushes=0.
//  Load-use and imem_wait together: single bubble (same outputs), one stall cycle counted.
//  stall_cycles++ whenever reset=0 and pc_load=0; clr_counters wins over increment; no wrap.
//  Reset mid-IND2: returns to RUN; pending indirect is discarded (pipeline regs also cleared).
// TESTING
//  LDR R1 in EX, ADD R2,R1,R3 in ID -> 1 cycle: pc_load=0,if_id_load=0,id_ex_flush=1; then all loads=1.
//  Same with id_src1_used=0 (src reg unused) or EN_LOAD_USE=0 -> no stall, all loads=1.
//  LDI in MEM, dmem_resp=1 at cycle 2 and 5 -> loads=0 cycles 0-4, mem_ind_sel=1 cycles 3-5, advance cycle 5.
//  mem_br_taken=1 with load-use and imem_wait=1 -> pc_load=1, three flushes=1, flush_events 0->1.
//  dmem_wait 3 cycles during mem_br_taken -> all loads=0 for 3 cycles, redirect on 4th; stall_cycles=3.
//  Force stall_cycles to 0xFFFF, stall again -> stays 0xFFFF; clr_counters -> 0; reset in IND2 -> RUN, outputs 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage LC-3b pipeline: load-use interlock, memory wait
// states, MEM-stage redirect, two-access LDI/STI sequencing and saturating perf counters.
module pipeline_hazard_ctrl #(
   parameter int CNT_WIDTH   = 16,
   parameter bit EN_LOAD_USE = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [2:0]           id_src1,
   input  logic [2:0]           id_src2,
   input  logic                 id_src1_used,
   input  logic                 id_src2_used,
   input  logic [2:0]           ex_dest,
   input  logic                 ex_is_load,
   input  logic                 imem_req,
   input  logic                 imem_resp,
   input  logic                 mem_dmem_req,
   input  logic                 dmem_resp,
   input  logic                 mem_is_indirect,
   input  logic                 mem_br_taken,
   input  logic                 clr_counters,
   output logic                 pc_load,
   output logic                 if_id_load,
   output logic                 id_ex_load,
   output logic                 ex_mem_load,
   output logic                 mem_wb_load,
   output logic                 if_id_flush,
   output logic                 id_ex_flush,
   output logic                 ex_mem_flush,
   output logic                 mem_ind_sel,
   output logic [CNT_WIDTH-1:0] stall_cycles,
   output logic [CNT_WIDTH-1:0] flush_events
);

   typedef enum logic [0:0] {RUN, IND2} state_t;

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;
   logic [CNT_WIDTH-1:0] flush_events_q, flush_events_d;
   logic                 dmem_wait, imem_wait, load_use, br_event;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   assign dmem_wait = mem_dmem_req & ~dmem_resp;
   assign imem_wait = imem_req & ~imem_resp;
   assign load_use  = EN_LOAD_USE & ex_is_load &
                      ((id_src1_used & (id_src1 == ex_dest)) |
                       (id_src2_used & (id_src2 == ex_dest)));

   always_comb begin
      state_d      = state_q;
      pc_load      = 1'b0;
      if_id_load   = 1'b0;
      id_ex_load   = 1'b0;
      ex_mem_load  = 1'b0;
      mem_wb_load  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      mem_ind_sel  = 1'b0;
      br_event     = 1'b0;
      if (reset) begin
         state_d = RUN;
      end else begin
         mem_ind_sel = (state_q == IND2);
         if (dmem_wait) begin
            state_d = state_q;
         end else if ((state_q == RUN) && mem_is_indirect && dmem_resp) begin
            // Pointer fetched; freeze everything while the second access is issued.
            state_d = IND2;
         end else if ((state_q == IND2) && !dmem_resp) begin
            state_d = IND2;
         end else begin
            state_d = RUN;
            if (mem_br_taken) begin
               // MEM/WB still loads so a JSR can write its link register.
               {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load} = 5'b11111;
               {if_id_flush, id_ex_flush, ex_mem_flush} = 3'b111;
               br_event = 1'b1;
            end else if (load_use || imem_wait) begin
               {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load} = 5'b00111;
               id_ex_flush = 1'b1;
            end else begin
               {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load} = 5'b11111;
            end
         end
      end
   end

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_events_d = flush_events_q;
      if (clr_counters) begin
         stall_cycles_d = '0;
         flush_events_d = '0;
      end else begin
         if (!reset && !pc_load && (stall_cycles_q != {CNT_WIDTH{1'b1}}))
            stall_cycles_d = stall_cycles_q + CNT_ONE;
         if (br_event && (flush_events_q != {CNT_WIDTH{1'b1}}))
            flush_events_d = flush_events_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= RUN;
         stall_cycles_q <= '0;
         flush_events_q <= '0;
      end else begin
         state_q        <= state_d;
         stall_cycles_q <= stall_cycles_d;
         flush_events_q <= flush_events_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_events = flush_events_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl: a driver queues expected controls and
// counters per cycle, a negedge monitor pops and compares against two DUT configurations.
module tb_pipeline_hazard_ctrl;

   typedef struct packed {
      logic       rst;
      logic [2:0] s1;
      logic [2:0] s2;
      logic       u1;
      logic       u2;
      logic [2:0] ed;
      logic       ld;
      logic       ireq;
      logic       iresp;
      logic       dreq;
      logic       dresp;
      logic       ind;
      logic       br;
      logic       clr;
   } in_t;

   typedef struct {
      string      name;
      logic [8:0] ctrl_a;
      logic [8:0] ctrl_b;
      bit         chk_cnt;
      logic [15:0] stall_a;
      logic [15:0] flush_a;
      logic [3:0]  stall_b;
   } exp_t;

   // ctrl = {pc, if_id, id_ex, ex_mem, mem_wb loads, if_id/id_ex/ex_mem flush, mem_ind_sel}
   localparam logic [8:0] C_ZERO = 9'b00000_000_0;
   localparam logic [8:0] C_ALL  = 9'b11111_000_0;
   localparam logic [8:0] C_BUB  = 9'b00111_010_0;
   localparam logic [8:0] C_BR   = 9'b11111_111_0;
   localparam logic [8:0] C_SEL  = 9'b00000_000_1;
   localparam logic [8:0] C_SELA = 9'b11111_000_1;

   logic clk = 1'b0;
   logic reset, clr_counters;
   logic [2:0] id_src1, id_src2, ex_dest;
   logic id_src1_used, id_src2_used, ex_is_load, imem_req, imem_resp;
   logic mem_dmem_req, dmem_resp, mem_is_indirect, mem_br_taken;
   logic pc_load_a, if_id_load_a, id_ex_load_a, ex_mem_load_a, mem_wb_load_a;
   logic if_id_flush_a, id_ex_flush_a, ex_mem_flush_a, mem_ind_sel_a;
   logic [15:0] stall_cycles_a, flush_events_a;
   logic pc_load_b, if_id_load_b, id_ex_load_b, ex_mem_load_b, mem_wb_load_b;
   logic if_id_flush_b, id_ex_flush_b, ex_mem_flush_b, mem_ind_sel_b;
   logic [3:0] stall_cycles_b, flush_events_b;

   int total = 0;
   int bad = 0;
   exp_t sb_q[$];
   in_t nxt;
   localparam in_t IDLE = '0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.CNT_WIDTH(16), .EN_LOAD_USE(1'b1)) dut_a (
      .clk(clk), .reset(reset),
      .id_src1(id_src1), .id_src2(id_src2),
      .id_src1_used(id_src1_used), .id_src2_used(id_src2_used),
      .ex_dest(ex_dest), .ex_is_load(ex_is_load),
      .imem_req(imem_req), .imem_resp(imem_resp),
      .mem_dmem_req(mem_dmem_req), .dmem_resp(dmem_resp),
      .mem_is_indirect(mem_is_indirect), .mem_br_taken(mem_br_taken),
      .clr_counters(clr_counters),
      .pc_load(pc_load_a), .if_id_load(if_id_load_a), .id_ex_load(id_ex_load_a),
      .ex_mem_load(ex_mem_load_a), .mem_wb_load(mem_wb_load_a),
      .if_id_flush(if_id_flush_a), .id_ex_flush(id_ex_flush_a), .ex_mem_flush(ex_mem_flush_a),
      .mem_ind_sel(mem_ind_sel_a),
      .stall_cycles(stall_cycles_a), .flush_events(flush_events_a)
   );

   // Narrow counters and interlock disabled: covers saturation and the debug mode.
   pipeline_hazard_ctrl #(.CNT_WIDTH(4), .EN_LOAD_USE(1'b0)) dut_b (
      .clk(clk), .reset(reset),
      .id_src1(id_src1), .id_src2(id_src2),
      .id_src1_used(id_src1_used), .id_src2_used(id_src2_used),
      .ex_dest(ex_dest), .ex_is_load(ex_is_load),
      .imem_req(imem_req), .imem_resp(imem_resp),
      .mem_dmem_req(mem_dmem_req), .dmem_resp(dmem_resp),
      .mem_is_indirect(mem_is_indirect), .mem_br_taken(mem_br_taken),
      .clr_counters(clr_counters),
      .pc_load(pc_load_b), .if_id_load(if_id_load_b), .id_ex_load(id_ex_load_b),
      .ex_mem_load(ex_mem_load_b), .mem_wb_load(mem_wb_load_b),
      .if_id_flush(if_id_flush_b), .id_ex_flush(id_ex_flush_b), .ex_mem_flush(ex_mem_flush_b),
      .mem_ind_sel(mem_ind_sel_b),
      .stall_cycles(stall_cycles_b), .flush_events(flush_events_b)
   );

   task automatic apply(input in_t i);
      reset = i.rst; id_src1 = i.s1; id_src2 = i.s2;
      id_src1_used = i.u1; id_src2_used = i.u2; ex_dest = i.ed; ex_is_load = i.ld;
      imem_req = i.ireq; imem_resp = i.iresp; mem_dmem_req = i.dreq; dmem_resp = i.dresp;
      mem_is_indirect = i.ind; mem_br_taken = i.br; clr_counters = i.clr;
   endtask

   task automatic vec(input string nm, input logic [8:0] ea, input logic [8:0] eb,
                      input bit cc, input int s, input int f, input int sbv);
      exp_t e;
      @(posedge clk);
      #1;
      apply(nxt);
      e.name = nm; e.ctrl_a = ea; e.ctrl_b = eb; e.chk_cnt = cc;
      e.stall_a = 16'(s); e.flush_a = 16'(f); e.stall_b = 4'(sbv);
      sb_q.push_back(e);
      $display("vec %-12s in=%h exp_a=%b exp_b=%b", nm, nxt, ea, eb);
   endtask

   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         logic [8:0] act_a, act_b;
         e = sb_q.pop_front();
         act_a = {pc_load_a, if_id_load_a, id_ex_load_a, ex_mem_load_a, mem_wb_load_a,
                  if_id_flush_a, id_ex_flush_a, ex_mem_flush_a, mem_ind_sel_a};
         act_b = {pc_load_b, if_id_load_b, id_ex_load_b, ex_mem_load_b, mem_wb_load_b,
                  if_id_flush_b, id_ex_flush_b, ex_mem_flush_b, mem_ind_sel_b};
         total++;
         if (act_a !== e.ctrl_a) begin
            bad++;
            $display("FAIL %s ctrl_a got=%b want=%b", e.name, act_a, e.ctrl_a);
         end
         total++;
         if (act_b !== e.ctrl_b) begin
            bad++;
            $display("FAIL %s ctrl_b got=%b want=%b", e.name, act_b, e.ctrl_b);
         end
         if (e.chk_cnt) begin
            total++;
            if (stall_cycles_a !== e.stall_a) begin
               bad++;
               $display("FAIL %s stall_a got=%0d want=%0d", e.name, stall_cycles_a, e.stall_a);
            end
            total++;
            if (flush_events_a !== e.flush_a) begin
               bad++;
               $display("FAIL %s flush_a got=%0d want=%0d", e.name, flush_events_a, e.flush_a);
            end
            total++;
            if (stall_cycles_b !== e.stall_b) begin
               bad++;
               $display("FAIL %s stall_b got=%0d want=%0d", e.name, stall_cycles_b, e.stall_b);
            end
         end
      end
   end

   initial begin
      int guard;
      nxt = IDLE; nxt.rst = 1'b1;
      apply(nxt);
      repeat (2) @(posedge clk);

      nxt = IDLE; nxt.rst = 1'b1;
      vec("reset", C_ZERO, C_ZERO, 1, 0, 0, 0);
      nxt = IDLE;
      vec("idle", C_ALL, C_ALL, 1, 0, 0, 0);
      // LDR R1 in EX, ADD R2,R1,R3 in ID
      nxt = IDLE; nxt.ld = 1; nxt.ed = 3'd1; nxt.s1 = 3'd1; nxt.u1 = 1; nxt.s2 = 3'd3; nxt.u2 = 1;
      vec("load_use", C_BUB, C_ALL, 1, 0, 0, 0);
      nxt = IDLE;
      vec("after_lu", C_ALL, C_ALL, 1, 1, 0, 0);
      nxt = IDLE; nxt.ld = 1; nxt.ed = 3'd1; nxt.s1 = 3'd1; nxt.u1 = 0; nxt.s2 = 3'd3; nxt.u2 = 1;
      vec("src_unused", C_ALL, C_ALL, 1, 1, 0, 0);
      nxt = IDLE; nxt.ireq = 1;
      vec("imem_wait", C_BUB, C_BUB, 1, 1, 0, 0);
      nxt = IDLE; nxt.ireq = 1; nxt.ld = 1; nxt.ed = 3'd1; nxt.s1 = 3'd1; nxt.u1 = 1;
      vec("lu_imem", C_BUB, C_BUB, 1, 2, 0, 1);
      nxt.br = 1;
      vec("br_over", C_BR, C_BR, 1, 3, 0, 2);
      nxt = IDLE;
      vec("after_br", C_ALL, C_ALL, 1, 3, 1, 2);
      nxt = IDLE; nxt.br = 1; nxt.dreq = 1;
      vec("dwait_br0", C_ZERO, C_ZERO, 1, 3, 1, 2);
      vec("dwait_br1", C_ZERO, C_ZERO, 1, 4, 1, 3);
      vec("dwait_br2", C_ZERO, C_ZERO, 1, 5, 1, 4);
      nxt.dresp = 1;
      vec("br_redir", C_BR, C_BR, 1, 6, 1, 5);
      nxt = IDLE; nxt.clr = 1;
      vec("clr", C_ALL, C_ALL, 1, 6, 2, 5);
      nxt = IDLE;
      vec("after_clr", C_ALL, C_ALL, 1, 0, 0, 0);
      // LDI: first access done at cycle 2, second at cycle 5
      nxt = IDLE; nxt.dreq = 1; nxt.ind = 1;
      vec("ldi_c0", C_ZERO, C_ZERO, 1, 0, 0, 0);
      vec("ldi_c1", C_ZERO, C_ZERO, 0, 0, 0, 0);
      nxt.dresp = 1;
      vec("ldi_c2", C_ZERO, C_ZERO, 0, 0, 0, 0);
      nxt.dresp = 0;
      vec("ldi_c3", C_SEL, C_SEL, 0, 0, 0, 0);
      vec("ldi_c4", C_SEL, C_SEL, 0, 0, 0, 0);
      nxt.dresp = 1;
      vec("ldi_c5", C_SELA, C_SELA, 1, 5, 0, 5);
      nxt = IDLE;
      vec("after_ldi", C_ALL, C_ALL, 1, 5, 0, 5);
      // Reset while in IND2
      nxt = IDLE; nxt.dreq = 1; nxt.ind = 1; nxt.dresp = 1;
      vec("ind_enter", C_ZERO, C_ZERO, 0, 0, 0, 0);
      nxt.dresp = 0; nxt.rst = 1;
      vec("ind_reset", C_ZERO, C_ZERO, 0, 0, 0, 0);
      nxt = IDLE;
      vec("post_reset", C_ALL, C_ALL, 1, 0, 0, 0);
      // Saturation of the 4-bit counter
      nxt = IDLE; nxt.ireq = 1;
      for (int k = 0; k < 20; k++) vec("sat_stall", C_BUB, C_BUB, 0, 0, 0, 0);
      nxt = IDLE;
      vec("sat_check", C_ALL, C_ALL, 1, 20, 0, 15);
      nxt = IDLE; nxt.clr = 1;
      vec("sat_clr", C_ALL, C_ALL, 1, 20, 0, 15);
      nxt = IDLE;
      vec("sat_zero", C_ALL, C_ALL, 1, 0, 0, 0);

      guard = 0;
      while (sb_q.size() > 0 && guard < 20) begin
         @(posedge clk);
         guard++;
      end
      if (sb_q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain pending=%0d want=0", sb_q.size());
      end
      @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
